vec_seq_check: RTL and testbench

VEC_SEQ_CHECK -- requirements
Module: vec_seq_check

---
 rtl/vec_seq_pkg.sv | 6 +
 rtl/bin2gray4.sv | 7 +
 rtl/vec_seq_check.sv | 78 +++++++
 tb/tb_vec_seq_check.sv | 120 ++++++++++++
 4 files changed

// File: rtl/vec_seq_pkg.sv
// vec_seq_pkg: shared state encoding and sizing constants for the vector sequencer
package vec_seq_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  localparam int NVEC = 16;
  localparam int VW = 4;
endpackage

// File: rtl/bin2gray4.sv
// bin2gray4: 4-bit binary to Gray code conversion
module bin2gray4 (
  input  logic [3:0] bin,
  output logic [3:0] gray
);
  assign gray = bin ^ {1'b0, bin[3:1]};
endmodule

// File: rtl/vec_seq_check.sv
// vec_seq_check: drives all 16 four-bit vectors and counts exp/act mismatches
module vec_seq_check
  import vec_seq_pkg::*;
#(
  parameter int DW = 4,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [DW-1:0] dwell,
  input  logic [VW-1:0] exp,
  input  logic [VW-1:0] act,
  output logic          x,
  output logic          y,
  output logic          z,
  output logic          m,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] err_cnt,
  output logic [VW-1:0] first_err_vec,
  output logic          first_err_valid
);
  state_t        state;
  logic [VW-1:0] idx;
  logic [VW-1:0] gray;
  logic [VW-1:0] vec;
  logic [DW-1:0] cnt;
  logic [DW-1:0] dwell_q;
  logic          mode_q;
  logic          last;
  bin2gray4 u_gray (.bin(idx), .gray(gray));
  assign vec = (state == DRIVE) ? (mode_q ? gray : idx) : '0;
  assign {x, y, z, m} = vec;
  assign busy = state == DRIVE;
  assign done = state == DONE;
  assign last = cnt == dwell_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      cnt             <= '0;
      mode_q          <= 1'b0;
      dwell_q         <= '0;
      err_cnt         <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state           <= DRIVE;
          idx             <= '0;
          cnt             <= '0;
          mode_q          <= mode;
          dwell_q         <= dwell;
          err_cnt         <= '0;
          first_err_vec   <= '0;
          first_err_valid <= 1'b0;
        end
        DRIVE: if (last) begin
          cnt <= '0;
          idx <= idx + VW'(1);
          if (idx == VW'(NVEC - 1)) state <= DONE;
          if (exp != act) begin
            err_cnt <= err_cnt + CW'(1);
            if (!first_err_valid) begin
              first_err_vec   <= vec;
              first_err_valid <= 1'b1;
            end
          end
        end else cnt <= cnt + DW'(1);
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_seq_check.sv
// tb_vec_seq_check: table-driven runs plus restart and mid-run reset sequences
module tb_vec_seq_check;
  localparam int DW = 4;
  localparam int CW = 5;
  localparam logic [3:0] gray_seq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                           4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  typedef struct {
    logic        md;
    int          dw;
    logic [15:0] mask;
    logic        nf;
    logic        rp;
    int          e_err;
    logic [3:0]  e_fv;
    logic        e_valid;
  } row_t;
  logic clk = 0, rst = 1, start = 0, mode = 0;
  logic [DW-1:0] dwell = '0;
  logic [3:0] exp = '0, act = '0;
  logic x, y, z, m, busy, done, first_err_valid;
  logic [CW-1:0] err_cnt;
  logic [3:0] first_err_vec;
  int checks = 0, errors = 0;
  row_t rows [6];
  vec_seq_check #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .dwell(dwell),
    .exp(exp), .act(act), .x(x), .y(y), .z(z), .m(m), .busy(busy), .done(done),
    .err_cnt(err_cnt), .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic chk_idle_zero(input string nm);
    chk({nm, "_vec"}, {x, y, z, m}, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err_cnt, 0);
    chk({nm, "_fv"}, first_err_vec, 0);
    chk({nm, "_valid"}, first_err_valid, 0);
  endtask
  task automatic run(input row_t r);
    int n = 16 * (r.dw + 1);
    start = 1; mode = r.md; dwell = r.dw[DW-1:0]; exp = 0; act = 0;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < n; c++) begin
      int i = c / (r.dw + 1);
      int p = c % (r.dw + 1);
      logic [3:0] ev = r.md ? gray_seq[i] : i[3:0];
      chk("vec", {x, y, z, m}, ev);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      exp = 4'($urandom);
      act = (r.mask[ev] && (r.nf ? p != r.dw : p == r.dw)) ? exp ^ 4'h6 : exp;
      start = r.rp && i == 7;
      @(negedge clk);
    end
    start = 0;
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_vec", {x, y, z, m}, 0);
    chk("err_cnt", err_cnt, r.e_err);
    chk("first_err_vec", first_err_vec, r.e_fv);
    chk("first_err_valid", first_err_valid, r.e_valid);
    exp = 4'h3; act = 4'hC;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("hold_err", err_cnt, r.e_err);
    chk("hold_fv", first_err_vec, r.e_fv);
    chk("hold_valid", first_err_valid, r.e_valid);
    exp = 0; act = 0;
  endtask
  initial begin
    rows[0] = '{md: 0, dw: 0, mask: 16'h0000, nf: 0, rp: 0, e_err: 0, e_fv: 4'h0, e_valid: 0};
    rows[1] = '{md: 1, dw: 0, mask: 16'h0000, nf: 0, rp: 0, e_err: 0, e_fv: 4'h0, e_valid: 0};
    rows[2] = '{md: 0, dw: 3, mask: 16'h0420, nf: 0, rp: 0, e_err: 2, e_fv: 4'h5, e_valid: 1};
    rows[3] = '{md: 0, dw: 2, mask: 16'h0008, nf: 1, rp: 0, e_err: 0, e_fv: 4'h0, e_valid: 0};
    rows[4] = '{md: 1, dw: 1, mask: 16'h1008, nf: 0, rp: 0, e_err: 2, e_fv: 4'h3, e_valid: 1};
    rows[5] = '{md: 0, dw: 0, mask: 16'h0000, nf: 0, rp: 1, e_err: 0, e_fv: 4'h0, e_valid: 0};
    @(negedge clk);
    @(negedge clk);
    chk_idle_zero("reset");
    rst = 0;
    @(negedge clk);
    chk_idle_zero("idle");
    foreach (rows[k]) run(rows[k]);
    // Seed one mismatch before aborting so the reset visibly clears err state
    start = 1; mode = 0; dwell = '0;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 9; c++) begin
      exp = 4'h1;
      act = (c == 2) ? 4'h8 : 4'h1;
      @(negedge clk);
    end
    chk("pre_abort_vec", {x, y, z, m}, 9);
    chk("pre_abort_err", err_cnt, 1);
    rst = 1; start = 1;
    @(negedge clk);
    rst = 0; start = 0;
    chk_idle_zero("abort");
    begin
      int seen = 0;
      for (int c = 0; c < 20; c++) begin
        if (done || busy) seen++;
        @(negedge clk);
      end
      chk("no_done_after_abort", seen, 0);
    end
    run(rows[2]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
